bf_result_collector: RTL

Downstream consumer of the 16-node Bellman-Ford datapath. It watches the datapath's distance bus and snapshots it on every external write strobe to track per-iteration change. On the rising edge of finish it captures the final distances, the iteration count and a negative-cycle flag. It then drains the 16 distances one word per handshake to the host-side bus interface.

---
 rtl/bf_result_collector.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/bf_result_collector.sv
// bf_result_collector: consumes the Bellman-Ford distance bus, tracks whether
// distances still change between write-strobe snapshots, captures the final
// distances on the rising edge of finish and drains them one word per
// valid/ready handshake.
//
// Ports:
//   clk, rst_global        clock (rising edge), asynchronous active-low reset
//   arm                    host pulse starting (or restarting) a collection run
//   write_enable_ext       datapath write strobe; rising edge takes a snapshot
//   finish                 datapath completion; rising edge captures results
//   iteration_counter      datapath iteration count, latched at capture
//   d_flat                 NODES distance words, word k at [k*DW +: DW]
//   out_data/out_index     drained word and its node index
//   out_valid/out_ready    drain handshake
//   out_last               marks the word of node NODES-1
//   busy                   run armed or draining
//   result_ready           results captured; cleared by the next arm
//   neg_cycle              distances changed at the last snapshot before finish
//   final_iter             iteration count at capture
//   snap_count             snapshots this run, saturating
module bf_result_collector #(
  parameter int unsigned NODES = 16,
  parameter int unsigned DW    = 32,
  parameter int unsigned IW    = 11
) (
  input  logic                       clk,
  input  logic                       rst_global,
  input  logic                       arm,
  input  logic                       write_enable_ext,
  input  logic                       finish,
  input  logic [IW-1:0]              iteration_counter,
  input  logic [NODES*DW-1:0]        d_flat,
  output logic [DW-1:0]              out_data,
  output logic [$clog2(NODES)-1:0]   out_index,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic                       result_ready,
  output logic                       neg_cycle,
  output logic [IW-1:0]              final_iter,
  output logic [IW-1:0]              snap_count
);

  localparam int unsigned IXW = $clog2(NODES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic                       we_q, fin_q;
  logic                       rise_we_c, rise_fin_c, chg_c;
  logic                       chg_last_q, chg_last_d;
  logic [NODES-1:0][DW-1:0]   shadow_q, shadow_d;
  logic [NODES-1:0][DW-1:0]   res_q, res_d;
  logic [IXW-1:0]             idx_q, idx_d;

  logic [DW-1:0]              out_data_d;
  logic [IXW-1:0]             out_index_d;
  logic                       out_valid_d, out_last_d, busy_d;
  logic                       result_ready_d, neg_cycle_d;
  logic [IW-1:0]              final_iter_d, snap_count_d;

  // Edge detection on the datapath strobes
  assign rise_we_c  = write_enable_ext & ~we_q;
  assign rise_fin_c = finish & ~fin_q;
  assign chg_c      = (d_flat != shadow_q);

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    chg_last_d     = chg_last_q;
    shadow_d       = shadow_q;
    res_d          = res_q;
    idx_d          = idx_q;
    out_data_d     = out_data;
    out_index_d    = out_index;
    out_valid_d    = out_valid;
    out_last_d     = out_last;
    result_ready_d = result_ready;
    neg_cycle_d    = neg_cycle;
    final_iter_d   = final_iter;
    snap_count_d   = snap_count;

    unique case (state_q)
      IDLE, ARMED: begin
        if (arm) begin
          // Arm starts a fresh run; in ARMED it also masks a coincident finish
          state_d        = ARMED;
          snap_count_d   = '0;
          neg_cycle_d    = 1'b0;
          shadow_d       = '0;
          chg_last_d     = 1'b0;
          result_ready_d = 1'b0;
        end else if (state_q == ARMED) begin
          if (rise_we_c) begin
            chg_last_d   = chg_c;
            shadow_d     = d_flat;
            snap_count_d = (snap_count == '1) ? snap_count : snap_count + IW'(1);
          end
          if (rise_fin_c) begin
            // A coincident snapshot feeds its fresh compare straight through
            res_d          = d_flat;
            final_iter_d   = iteration_counter;
            neg_cycle_d    = rise_we_c ? chg_c : chg_last_q;
            result_ready_d = 1'b1;
            idx_d          = '0;
            out_valid_d    = 1'b1;
            out_data_d     = d_flat[DW-1:0];
            out_index_d    = '0;
            out_last_d     = (NODES == 1);
            state_d        = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (out_last) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
            out_index_d = '0;
            idx_d       = '0;
          end else begin
            idx_d       = idx_q + IXW'(1);
            out_data_d  = res_q[idx_d];
            out_index_d = idx_d;
            out_last_d  = (idx_d == IXW'(NODES - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_global) begin
    if (!rst_global) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      fin_q        <= 1'b0;
      chg_last_q   <= 1'b0;
      shadow_q     <= '0;
      res_q        <= '0;
      idx_q        <= '0;
      out_data     <= '0;
      out_index    <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      result_ready <= 1'b0;
      neg_cycle    <= 1'b0;
      final_iter   <= '0;
      snap_count   <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= write_enable_ext;
      fin_q        <= finish;
      chg_last_q   <= chg_last_d;
      shadow_q     <= shadow_d;
      res_q        <= res_d;
      idx_q        <= idx_d;
      out_data     <= out_data_d;
      out_index    <= out_index_d;
      out_valid    <= out_valid_d;
      out_last     <= out_last_d;
      busy         <= busy_d;
      result_ready <= result_ready_d;
      neg_cycle    <= neg_cycle_d;
      final_iter   <= final_iter_d;
      snap_count   <= snap_count_d;
    end
  end

endmodule
